cache_ctrl_assoc: RTL and testbench
===================================

CACHE_CTRL_ASSOC -- requirements
Module: cache_ctrl_assoc

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 32, data and address width.
REQ-002 SHALL have parameter NUM_SETS, default 16, number of sets; power of two, >= 2.
REQ-003 SHALL have parameter NUM_WAYS, default 2, ways per set; power of two, >= 1.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-006 SHALL have port req_valid  input  1  CPU request present.
REQ-007 SHALL have port req_ready  output  1  controller can accept a request.
REQ-008 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-009 SHALL have port req_addr  input  WORD_SIZE  word address.
REQ-010 SHALL have port req_wdata  input  WORD_SIZE  write data.
REQ-011 SHALL have port resp_valid  output  1  one-cycle response strobe.
REQ-012 SHALL have port resp_rdata  output  WORD_SIZE  read data; 0 for writes.
REQ-013 SHALL have port resp_hit  output  1  request hit in cache.
REQ-014 SHALL have ports mem_req (out 1), mem_we (out 1), mem_addr (out WORD_SIZE), mem_wdata (out WORD_SIZE): backing-memory request.
REQ-015 SHALL have ports mem_ack (in 1), mem_rdata (in WORD_SIZE): one-cycle memory completion and read data.
REQ-016 SHALL have ports hit_count and miss_count, output, 32 bits each.

Function
REQ-017 SHALL organise storage as NUM_SETS x NUM_WAYS one-word lines, each with valid, dirty, tag, data.
REQ-018 SHALL decode index = req_addr[log2(NUM_SETS)-1:0] and tag = the remaining upper bits.
REQ-019 SHALL implement FSM states IDLE, LOOKUP, WRITEBACK, FILL, RESPOND.
REQ-020 SHALL drive req_ready high only in IDLE; a request is accepted on an edge with req_valid && req_ready, registering we/addr/wdata and entering LOOKUP.
REQ-021 SHALL ignore req_valid in every state other than IDLE.
REQ-022 SHALL in LOOKUP compare tag against all valid ways of the set; hit goes to RESPOND next edge.
REQ-023 SHALL on a hit deliver resp_valid in the second cycle after the accepting edge.
REQ-024 SHALL select a miss victim as the lowest-index invalid way, else the way indicated by a per-set round-robin pointer.
REQ-025 SHALL advance a set's round-robin pointer by one (mod NUM_WAYS) on every allocation in that set.
REQ-026 SHALL on a miss go to WRITEBACK if the victim is valid and dirty, otherwise to FILL for a read or RESPOND for a write.
REQ-027 SHALL in WRITEBACK hold mem_req=1, mem_we=1, mem_addr={victim tag,index}, mem_wdata=victim data until mem_ack, then go to FILL (read) or RESPOND (write).
REQ-028 SHALL in FILL hold mem_req=1, mem_we=0, mem_addr=request address until mem_ack, capture mem_rdata into the victim way (valid=1, dirty=0), then go to RESPOND.
REQ-029 SHALL on a write miss allocate without memory fetch (single-word lines).
REQ-030 SHALL on any write (hit or allocated miss) store req_wdata and set valid=1, dirty=1.
REQ-031 SHALL in RESPOND assert resp_valid for exactly one cycle with resp_hit and resp_rdata, then return to IDLE; no response backpressure.
REQ-032 SHALL keep mem_req low outside WRITEBACK/FILL and ignore mem_ack when mem_req is low.
REQ-033 SHALL increment hit_count or miss_count once per request at LOOKUP resolution, saturating at 0xFFFFFFFF.

Reset
REQ-034 SHALL on rst clear all valid, dirty and round-robin bits, enter IDLE, and clear hit_count, miss_count, resp_valid, resp_hit, resp_rdata, mem_req, mem_we, mem_addr, mem_wdata.
REQ-035 SHALL on rst during WRITEBACK or FILL abandon the transaction, dropping mem_req at that edge, with no response issued; dirty data is lost.
REQ-036 SHALL give rst priority over a simultaneous req_valid or mem_ack.

Verification
REQ-037 Cold write 0x10 = 0xA5A5A5A5 then read 0x10 -> write: resp_hit=0, no mem_req; read: resp_hit=1, rdata 0xA5A5A5A5, resp_valid 2 cycles after accept; hit_count=1, miss_count=1.
REQ-038 Cold read 0x11, memory acks 3 cycles after mem_req with 0xDEADBEEF -> mem_we=0, mem_addr 0x11; resp_rdata 0xDEADBEEF, resp_hit=0; re-read 0x11 hits.
REQ-039 Writes 0x10, 0x20, 0x30 (all set 0, 2 ways) -> third write issues writeback mem_addr 0x10, mem_wdata 0xA5A5A5A5; then read 0x10 misses and fills from memory.
REQ-040 Hold req_valid=1 with read 0x40 while a FILL is pending -> req_ready=0, request accepted only on the first IDLE edge after RESPOND.
REQ-041 Assert rst for 1 cycle mid-FILL -> mem_req=0 after that edge, no resp_valid, counters 0, read 0x11 afterwards misses.
REQ-042 Force hit_count to saturation via 2^32 hits (or a forced-init variant) -> stays 0xFFFFFFFF on further hits.

Source files
------------

// File: rtl/cache_ctrl_assoc.sv
// cache_ctrl_assoc: set-associative, write-back / write-allocate cache
// controller with single-word lines and a round-robin replacement pointer
// per set.
//
// Ports
//   clk, rst              : clock; synchronous active-high reset
//   req_valid/req_ready   : CPU request handshake (ready only while idle)
//   req_we/addr/wdata     : CPU request (1 = write), word address, write data
//   resp_valid            : one-cycle response strobe
//   resp_hit/resp_rdata   : hit flag and read data (0 for writes)
//   mem_req/we/addr/wdata : backing-memory request, held until mem_ack
//   mem_ack/mem_rdata     : one-cycle memory completion and read data
//   hit_count/miss_count  : saturating 32-bit event counters
module cache_ctrl_assoc #(
  parameter int WORD_SIZE = 32,
  parameter int NUM_SETS  = 16,
  parameter int NUM_WAYS  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [WORD_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [WORD_SIZE-1:0] resp_rdata,
  output logic                 resp_hit,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic                 mem_ack,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = WORD_SIZE - IDX_W;
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOOKUP    = 3'd1,
    S_WRITEBACK = 3'd2,
    S_FILL      = 3'd3,
    S_RESPOND   = 3'd4
  } state_e;

  state_e state_q, state_d;

  // Captured request
  logic                 we_q;
  logic [WORD_SIZE-1:0] addr_q;
  logic [WORD_SIZE-1:0] wdata_q;
  logic [WAY_W-1:0]     victim_q;

  // Line storage
  logic                 valid_q [NUM_SETS][NUM_WAYS];
  logic                 dirty_q [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]     tag_q   [NUM_SETS][NUM_WAYS];
  logic [WORD_SIZE-1:0] data_q  [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0]     rr_q    [NUM_SETS];

  logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

  logic                 req_ready_q, req_ready_d;
  logic                 resp_valid_q, resp_valid_d;
  logic                 resp_hit_q, resp_hit_d;
  logic [WORD_SIZE-1:0] resp_rdata_q, resp_rdata_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [WORD_SIZE-1:0] mem_addr_q, mem_addr_d;
  logic [WORD_SIZE-1:0] mem_wdata_q, mem_wdata_d;

  // Lookup / victim selection signals
  logic [IDX_W-1:0]     idx_s;
  logic [TAG_W-1:0]     tag_s;
  logic                 hit_s;
  logic [WAY_W-1:0]     hit_way_s;
  logic [WAY_W-1:0]     victim_s;
  logic [WAY_W-1:0]     vic_way_s;
  logic                 vic_evict_s;
  logic [WAY_W-1:0]     rr_next_s;

  // Line write port
  logic                 wr_en_s;
  logic [WAY_W-1:0]     wr_way_s;
  logic [WORD_SIZE-1:0] wr_data_s;
  logic                 wr_dirty_s;

  assign idx_s = addr_q[IDX_W-1:0];
  assign tag_s = addr_q[WORD_SIZE-1:IDX_W];

  // Tag compare across all ways; victim = lowest invalid way, else round-robin
  always_comb begin
    hit_s     = 1'b0;
    hit_way_s = '0;
    victim_s  = rr_q[idx_s];
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      hit_s     = hit_s | (valid_q[idx_s][w] && (tag_q[idx_s][w] == tag_s));
      hit_way_s = (valid_q[idx_s][w] && (tag_q[idx_s][w] == tag_s)) ? WAY_W'(w) : hit_way_s;
      victim_s  = (!valid_q[idx_s][w]) ? WAY_W'(w) : victim_s;
    end
  end

  // The victim is only chosen in LOOKUP; afterwards the latched copy is used
  // because the round-robin pointer has already moved on.
  assign vic_way_s   = (state_q == S_LOOKUP) ? victim_s : victim_q;
  assign vic_evict_s = valid_q[idx_s][vic_way_s] && dirty_q[idx_s][vic_way_s];
  assign rr_next_s   = (rr_q[idx_s] == WAY_W'(NUM_WAYS - 1)) ? '0 : rr_q[idx_s] + WAY_W'(1);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) state_d = S_LOOKUP;
        else           state_d = S_IDLE;
      end
      S_LOOKUP: begin
        if (hit_s)            state_d = S_RESPOND;
        else if (vic_evict_s) state_d = S_WRITEBACK;
        else if (we_q)        state_d = S_RESPOND;
        else                  state_d = S_FILL;
      end
      S_WRITEBACK: begin
        if (mem_ack) state_d = we_q ? S_RESPOND : S_FILL;
        else         state_d = S_WRITEBACK;
      end
      S_FILL: begin
        if (mem_ack) state_d = S_RESPOND;
        else         state_d = S_FILL;
      end
      S_RESPOND: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM output logic: next values of the registered outputs and the line write port
  always_comb begin
    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESPOND);
    resp_hit_d   = 1'b0;
    resp_rdata_d = '0;
    mem_req_d    = (state_d == S_WRITEBACK) || (state_d == S_FILL);
    mem_we_d     = (state_d == S_WRITEBACK);
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    wr_en_s      = 1'b0;
    wr_way_s     = vic_way_s;
    wr_data_s    = wdata_q;
    wr_dirty_s   = 1'b1;
    if (state_d == S_WRITEBACK) begin
      mem_addr_d  = {tag_q[idx_s][vic_way_s], idx_s};
      mem_wdata_d = data_q[idx_s][vic_way_s];
    end else if (state_d == S_FILL) begin
      mem_addr_d = addr_q;
    end else begin
      mem_addr_d = '0;
    end
    case (state_q)
      S_LOOKUP: begin
        if (hit_s) begin
          resp_hit_d   = 1'b1;
          resp_rdata_d = we_q ? '0 : data_q[idx_s][hit_way_s];
          wr_en_s      = we_q;
          wr_way_s     = hit_way_s;
        end else begin
          // write miss with a clean victim allocates immediately
          wr_en_s = we_q && !vic_evict_s;
        end
      end
      S_WRITEBACK: begin
        wr_en_s = mem_ack && we_q;
      end
      S_FILL: begin
        wr_en_s      = mem_ack;
        wr_data_s    = mem_rdata;
        wr_dirty_s   = 1'b0;
        resp_rdata_d = mem_ack ? mem_rdata : '0;
      end
      default: begin
        wr_en_s = 1'b0;
      end
    endcase
  end

  // Saturating hit/miss counters, resolved in LOOKUP
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (state_q == S_LOOKUP && hit_s && hit_cnt_q != CNT_MAX) begin
      hit_cnt_d = hit_cnt_q + 32'd1;
    end else if (state_q == S_LOOKUP && !hit_s && miss_cnt_q != CNT_MAX) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end else begin
      hit_cnt_d = hit_cnt_q;
    end
  end

  // Request capture, victim latch, counters and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      victim_q     <= '0;
      hit_cnt_q    <= 32'd0;
      miss_cnt_q   <= 32'd0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      if (state_q == S_IDLE && req_valid) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (state_q == S_LOOKUP) begin
        victim_q <= victim_s;
      end
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_rdata_q <= resp_rdata_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  // Line status bits and round-robin pointers (cleared by reset)
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        rr_q[s] <= '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
        end
      end
    end else begin
      if (wr_en_s) begin
        valid_q[idx_s][wr_way_s] <= 1'b1;
        dirty_q[idx_s][wr_way_s] <= wr_dirty_s;
      end
      if (state_q == S_LOOKUP && !hit_s) begin
        rr_q[idx_s] <= rr_next_s;
      end
    end
  end

  // Line tag and data arrays (contents qualified by valid, so no reset)
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      tag_q[idx_s][wr_way_s]  <= tag_s;
      data_q[idx_s][wr_way_s] <= wr_data_s;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_hit   = resp_hit_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_cache_ctrl_assoc.sv
// Self-checking bench for cache_ctrl_assoc: directed scenarios followed by
// randomized traffic, checked against a transaction-level cache model.
module tb_cache_ctrl_assoc;
  localparam int NS = 16;
  localparam int NW = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
  logic        req_ready, resp_valid, resp_hit;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic [31:0] hit_count, miss_count;

  cache_ctrl_assoc #(.WORD_SIZE(32), .NUM_SETS(NS), .NUM_WAYS(NW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } op_t;

  op_t obs_q[$];
  op_t exp_q[$];

  function automatic logic [31:0] mem_init(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  // Backing memory seen by the DUT
  logic [31:0] mem_arr [logic [31:0]];
  int mem_lat = 2;
  int mem_cnt = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (mem_ack) begin
        mem_ack = 1'b0;
        mem_cnt = 0;
      end else if (mem_req) begin
        mem_cnt++;
        if (mem_cnt >= mem_lat) begin
          mem_ack = 1'b1;
          obs_q.push_back({mem_we, mem_addr, mem_we ? mem_wdata : 32'd0});
          if (mem_we) mem_arr[mem_addr] = mem_wdata;
          else        mem_rdata = mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : mem_init(mem_addr);
        end
      end else begin
        mem_cnt = 0;
      end
    end
  end

  // Reference model: cache contents plus its own view of memory
  logic        m_valid [NS][NW];
  logic        m_dirty [NS][NW];
  logic [31:0] m_tag   [NS][NW];
  logic [31:0] m_data  [NS][NW];
  int          m_rr    [NS];
  logic [31:0] m_mem   [logic [31:0]];
  logic [31:0] m_hits, m_misses;
  logic        exp_hit;
  logic [31:0] exp_rdata;

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < NW; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
      end
    end
    m_hits = 32'd0;
    m_misses = 32'd0;
  endtask

  task automatic model_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    int s, hw, v;
    logic [31:0] t, wb_addr;
    s = int'(addr % 32'(NS));
    t = addr / 32'(NS);
    hw = -1;
    for (int w = 0; w < NW; w++) if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
    if (hw >= 0) begin
      exp_hit = 1'b1;
      if (m_hits != 32'hFFFF_FFFF) m_hits = m_hits + 32'd1;
      if (we) begin
        m_data[s][hw] = wdata;
        m_dirty[s][hw] = 1'b1;
        exp_rdata = 32'd0;
      end else begin
        exp_rdata = m_data[s][hw];
      end
    end else begin
      exp_hit = 1'b0;
      if (m_misses != 32'hFFFF_FFFF) m_misses = m_misses + 32'd1;
      v = -1;
      for (int w = 0; w < NW; w++) if (!m_valid[s][w] && v < 0) v = w;
      if (v < 0) v = m_rr[s];
      m_rr[s] = (m_rr[s] + 1) % NW;
      if (m_valid[s][v] && m_dirty[s][v]) begin
        wb_addr = m_tag[s][v] * 32'(NS) + 32'(s);
        exp_q.push_back({1'b1, wb_addr, m_data[s][v]});
        m_mem[wb_addr] = m_data[s][v];
      end
      m_valid[s][v] = 1'b1;
      m_tag[s][v] = t;
      if (we) begin
        m_data[s][v] = wdata;
        m_dirty[s][v] = 1'b1;
        exp_rdata = 32'd0;
      end else begin
        exp_q.push_back({1'b0, addr, 32'd0});
        m_data[s][v] = m_mem.exists(addr) ? m_mem[addr] : mem_init(addr);
        m_dirty[s][v] = 1'b0;
        exp_rdata = m_data[s][v];
      end
    end
  endtask

  // Waits (bounded) for the response of an accepted request and checks it
  task automatic wait_resp(input string tag, input bit chk_busy);
    int lat;
    op_t o, e;
    lat = 1;
    while (!resp_valid && lat < 100) begin
      if (chk_busy) check_val({tag, "_ready_busy"}, 64'(req_ready), 64'd0);
      @(negedge clk);
      lat++;
    end
    check_val({tag, "_resp_valid"}, 64'(resp_valid), 64'd1);
    check_val({tag, "_hit"}, 64'(resp_hit), 64'(exp_hit));
    check_val({tag, "_rdata"}, 64'(resp_rdata), 64'(exp_rdata));
    if (exp_hit) check_val({tag, "_hit_latency"}, 64'(lat), 64'd2);
    check_val({tag, "_mem_ops"}, 64'(obs_q.size()), 64'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      check_val({tag, "_mem_we"}, 64'(o.we), 64'(e.we));
      check_val({tag, "_mem_addr"}, 64'(o.addr), 64'(e.addr));
      check_val({tag, "_mem_wdata"}, 64'(o.data), 64'(e.data));
    end
    obs_q.delete();
    exp_q.delete();
    @(negedge clk);
    check_val({tag, "_resp_one_cycle"}, 64'(resp_valid), 64'd0);
    check_val({tag, "_ready_idle"}, 64'(req_ready), 64'd1);
    check_val({tag, "_hit_count"}, 64'(hit_count), 64'(m_hits));
    check_val({tag, "_miss_count"}, 64'(miss_count), 64'(m_misses));
  endtask

  // Issues one request from a negedge, with the DUT idle
  task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata);
    check_val({tag, "_ready_start"}, 64'(req_ready), 64'd1);
    req_we = we;
    req_addr = addr;
    req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk);
    model_req(we, addr, wdata);
    @(negedge clk);
    req_valid = 1'b0;
    wait_resp(tag, 1'b1);
  endtask

  logic [31:0] last_addr;

  initial begin
    mem_arr[32'h11] = 32'hDEAD_BEEF;
    m_mem[32'h11] = 32'hDEAD_BEEF;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_val("rst_ready", 64'(req_ready), 64'd1);
    check_val("rst_resp_valid", 64'(resp_valid), 64'd0);
    check_val("rst_resp_hit", 64'(resp_hit), 64'd0);
    check_val("rst_resp_rdata", 64'(resp_rdata), 64'd0);
    check_val("rst_mem_req", 64'(mem_req), 64'd0);
    check_val("rst_mem_addr", 64'(mem_addr), 64'd0);
    check_val("rst_hits", 64'(hit_count), 64'd0);
    check_val("rst_misses", 64'(miss_count), 64'd0);

    // Cold write then read back
    do_req("w10", 1'b1, 32'h10, 32'hA5A5_A5A5);
    do_req("r10", 1'b0, 32'h10, 32'd0);
    check_val("r10_counts", 64'({hit_count, miss_count}), 64'({32'd1, 32'd1}));

    // Cold read filled after a 3-cycle memory delay, then a hit
    mem_lat = 3;
    do_req("r11", 1'b0, 32'h11, 32'd0);
    do_req("r11_again", 1'b0, 32'h11, 32'd0);

    // Three writes into set 0 force a writeback of 0x10, then 0x10 refills
    do_req("w10b", 1'b1, 32'h10, 32'hA5A5_A5A5);
    do_req("w20", 1'b1, 32'h20, 32'h2020_2020);
    do_req("w30", 1'b1, 32'h30, 32'h3030_3030);
    do_req("r10_refill", 1'b0, 32'h10, 32'd0);

    // Request held valid while a fill is in progress
    req_we = 1'b0;
    req_wdata = 32'd0;
    req_addr = 32'h50;
    req_valid = 1'b1;
    @(posedge clk);
    model_req(1'b0, 32'h50, 32'd0);
    @(negedge clk);
    req_addr = 32'h40;
    wait_resp("hold50", 1'b1);
    @(posedge clk);
    model_req(1'b0, 32'h40, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    wait_resp("held40", 1'b1);

    // Reset in the middle of a fill
    req_we = 1'b0;
    req_addr = 32'h61;
    req_valid = 1'b1;
    @(posedge clk);
    model_req(1'b0, 32'h61, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 20 && !(mem_req && !mem_we); i++) @(negedge clk);
    check_val("abort_fill_seen", 64'(mem_req && !mem_we), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    obs_q.delete();
    exp_q.delete();
    check_val("abort_mem_req", 64'(mem_req), 64'd0);
    check_val("abort_hits", 64'(hit_count), 64'd0);
    check_val("abort_misses", 64'(miss_count), 64'd0);
    for (int i = 0; i < 5; i++) begin
      check_val("abort_no_resp", 64'(resp_valid), 64'd0);
      @(negedge clk);
    end
    do_req("r11_after_rst", 1'b0, 32'h11, 32'd0);
    check_val("r11_after_rst_miss", 64'(resp_hit === 1'b0 && miss_count == 32'd1), 64'd1);

    // Randomized traffic over a few tags per set
    last_addr = 32'd0;
    for (int i = 0; i < 150; i++) begin
      mem_lat = int'($urandom_range(1, 4));
      last_addr = 32'($urandom_range(0, 63));
      do_req("rand", 1'($urandom_range(0, 1)), last_addr, $urandom);
    end

    // Saturation of the hit counter
    @(negedge clk);
    force dut.hit_cnt_q = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut.hit_cnt_q;
    m_hits = 32'hFFFF_FFFE;
    do_req("sat1", 1'b0, last_addr, 32'd0);
    do_req("sat2", 1'b0, last_addr, 32'd0);
    check_val("sat_hold", 64'(hit_count), 64'h0000_0000_FFFF_FFFF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
